// File: rtl/joypad_multi_port_if.sv
// ---------------------------------------------------------------------------
// joypad_multi_port_if
// Bundles the pad-side signals of the multi-pad NES controller port.
//   master : NES core / host side (drives strobe, read clocks and button
//            sources; receives serial data and status)
//   slave  : the controller port itself
// Signals
//   strobe      NES latch, high = continuous reload of every pad
//   pad_clk     per-pad read clock, shifts on its falling edge
//   btn_in      pressed buttons, pad p at [p*BTN_BITS +: BTN_BITS]
//   turbo_in    per-button autofire request
//   override    host/loader buttons, ORed in unconditionally
//   pad_data    current serial bit per pad
//   reads_done  BTN_BITS shifts seen since the last strobe, per pad
//   turbo_phase current autofire phase per pad
// ---------------------------------------------------------------------------
interface joypad_multi_port_if #(
   parameter int NUM_PADS = 2,
   parameter int BTN_BITS = 8
);
   logic                         strobe;
   logic [NUM_PADS-1:0]          pad_clk;
   logic [NUM_PADS*BTN_BITS-1:0] btn_in;
   logic [NUM_PADS*BTN_BITS-1:0] turbo_in;
   logic [NUM_PADS*BTN_BITS-1:0] override;
   logic [NUM_PADS-1:0]          pad_data;
   logic [NUM_PADS-1:0]          reads_done;
   logic [NUM_PADS-1:0]          turbo_phase;

   modport master (
      output strobe, pad_clk, btn_in, turbo_in, override,
      input  pad_data, reads_done, turbo_phase
   );

   modport slave (
      input  strobe, pad_clk, btn_in, turbo_in, override,
      output pad_data, reads_done, turbo_phase
   );
endinterface

// File: rtl/joypad_multi_port.sv
// ---------------------------------------------------------------------------
// joypad_multi_port
// Generalised NES controller port serving NUM_PADS independent serial pads.
// Each pad has a strobe-latched shift register, per-button autofire and a
// host override OR.
// Ports
//   clk    system clock
//   reset  synchronous, active-high
//   bus    joypad_multi_port_if.slave (strobe, pad_clk, button sources in;
//          pad_data, reads_done, turbo_phase out)
// ---------------------------------------------------------------------------
module joypad_multi_port #(
   parameter int   NUM_PADS   = 2,
   parameter int   BTN_BITS   = 8,
   parameter int   FREQ       = 25_000_000,
   parameter int   TURBO_HZ   = 15,
   parameter logic SHIFT_FILL = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   joypad_multi_port_if.slave    bus
);

   localparam int HALF  = FREQ / (2 * TURBO_HZ);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int BC_W  = $clog2(BTN_BITS + 1);

   // Bit counter saturates at BTN_BITS so reads_done stays asserted on
   // over-reads.
   function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] v);
      if (v >= BC_W'(BTN_BITS)) begin
         return v;
      end
      return v + BC_W'(1);
   endfunction

   logic [NUM_PADS-1:0] data_v;
   logic [NUM_PADS-1:0] done_v;
   logic [NUM_PADS-1:0] phase_v;

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      logic [CNT_W-1:0]    tcnt_q, tcnt_d;
      logic                phase_q, phase_d;
      logic [BTN_BITS-1:0] sreg_q, sreg_d;
      logic [BC_W-1:0]     bcnt_q, bcnt_d;
      logic                last_q;
      logic                data_q, data_d;
      logic                done_q, done_d;
      logic [BTN_BITS-1:0] btn, turbo, ovr, comb;
      logic                any_turbo;
      logic                fall;

      assign btn       = bus.btn_in  [p*BTN_BITS +: BTN_BITS];
      assign turbo     = bus.turbo_in[p*BTN_BITS +: BTN_BITS];
      assign ovr       = bus.override[p*BTN_BITS +: BTN_BITS];
      assign any_turbo = |turbo;
      assign comb      = btn | ovr | (turbo & {BTN_BITS{phase_q}});
      assign fall      = last_q & ~bus.pad_clk[p];

      always_comb begin
         tcnt_d  = tcnt_q;
         phase_d = phase_q;
         sreg_d  = sreg_q;
         bcnt_d  = bcnt_q;
         done_d  = done_q;

         // Idle autofire parks at phase 1 so a fresh press reads as pressed
         // for a full half period.
         if (!any_turbo) begin
            tcnt_d  = '0;
            phase_d = 1'b1;
         end else if (tcnt_q == CNT_W'(HALF - 1)) begin
            tcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            tcnt_d  = tcnt_q + CNT_W'(1);
         end

         // Load wins over a coincident falling edge.
         if (bus.strobe) begin
            sreg_d = comb;
            bcnt_d = '0;
            done_d = 1'b0;
         end else if (fall) begin
            sreg_d = {SHIFT_FILL, sreg_q[BTN_BITS-1:1]};
            bcnt_d = sat_inc(bcnt_q);
            done_d = (sat_inc(bcnt_q) == BC_W'(BTN_BITS));
         end

         data_d = sreg_d[0];
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            tcnt_q  <= '0;
            phase_q <= 1'b1;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            last_q  <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            tcnt_q  <= tcnt_d;
            phase_q <= phase_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            last_q  <= bus.pad_clk[p];
            data_q  <= data_d;
            done_q  <= done_d;
         end
      end

      assign data_v[p]  = data_q;
      assign done_v[p]  = done_q;
      assign phase_v[p] = phase_q;
   end

   assign bus.pad_data    = data_v;
   assign bus.reads_done  = done_v;
   assign bus.turbo_phase = phase_v;

endmodule

// File: tb/tb_joypad_multi_port.sv
// ---------------------------------------------------------------------------
// tb_joypad_multi_port
// Self-checking bench for joypad_multi_port (2 pads x 8 buttons, HALF = 5).
// Observed vector per check is {turbo_phase, reads_done, pad_data}.
// ---------------------------------------------------------------------------
module tb_joypad_multi_port;

   localparam int NP = 2;
   localparam int BB = 8;

   localparam logic [5:0] M_DATA = 6'b000011;
   localparam logic [5:0] M_DONE = 6'b001100;
   localparam logic [5:0] M_PH   = 6'b110000;
   localparam logic [5:0] M_ALL  = 6'b111111;

   logic clk;
   logic reset;

   joypad_multi_port_if #(.NUM_PADS(NP), .BTN_BITS(BB)) jif ();

   joypad_multi_port #(
      .NUM_PADS  (NP),
      .BTN_BITS  (BB),
      .FREQ      (100),
      .TURBO_HZ  (10),
      .SHIFT_FILL(1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (jif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [5:0] exp;
      logic [5:0] mask;
   } sb_t;

   typedef struct {
      logic [7:0] btn0, ovr0, btn1, ovr1;
      logic [7:0] exp0, exp1;
   } vec_t;

   sb_t  sbq[$];
   vec_t tbl[4];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_check();
      sb_t        e;
      logic [5:0] act;
      n_total++;
      if (sbq.size() == 0) begin
         $display("FAIL sb_empty: no expected record queued");
         return;
      end
      e   = sbq.pop_front();
      act = {jif.turbo_phase, jif.reads_done, jif.pad_data};
      if ((act & e.mask) === (e.exp & e.mask)) n_pass++;
      else $display("FAIL %s: got {ph,done,data}=%b required %b (mask %b)",
                    e.name, act, e.exp, e.mask);
   endtask

   // Queue the expectation for the cycle being driven, clock it, compare.
   task automatic step(input string name, input logic [1:0] data,
                       input logic [1:0] done, input logic [1:0] ph,
                       input logic [5:0] mask);
      sb_t e;
      e.name = name;
      e.exp  = {ph, done, data};
      e.mask = mask;
      sbq.push_back(e);
      tick();
      sb_check();
   endtask

   task automatic fall(input logic [1:0] pads, input string name,
                       input logic [1:0] data, input logic [1:0] done,
                       input logic [5:0] mask);
      jif.pad_clk = pads;
      tick();
      jif.pad_clk = 2'b00;
      step(name, data, done, 2'b11, mask);
   endtask

   function automatic logic bit_at(input logic [7:0] v, input int idx);
      return (idx >= BB) ? 1'b1 : v[idx];
   endfunction

   // Load a vector, scramble the live buttons, then shift the selected pads
   // nfall times and compare the serial stream against the expected bytes.
   task automatic run_vec(input vec_t v, input logic [1:0] pads,
                          input int nfall, input string tag);
      int         i0, i1;
      logic [1:0] d, dn;
      jif.btn_in   = {v.btn1, v.btn0};
      jif.override = {v.ovr1, v.ovr0};
      jif.strobe   = 1'b1;
      step({tag, "_load"}, {v.exp1[0], v.exp0[0]}, 2'b00, 2'b11, M_DATA | M_DONE);
      jif.strobe   = 1'b0;
      jif.btn_in   = ~{v.btn1, v.btn0};
      jif.override = '0;
      for (int k = 1; k <= nfall; k++) begin
         i0 = pads[0] ? k : 0;
         i1 = pads[1] ? k : 0;
         d  = {bit_at(v.exp1, i1), bit_at(v.exp0, i0)};
         dn = {(i1 >= BB), (i0 >= BB)};
         fall(pads, $sformatf("%s_shift%0d", tag, k), d, dn, M_DATA | M_DONE);
      end
   endtask

   function automatic logic exp_ph(input int k);
      return ((k / 5) % 2) == 0;
   endfunction

   initial begin
      vec_t hv;

      tbl[0] = '{btn0: 8'hA5, ovr0: 8'h00, btn1: 8'h00, ovr1: 8'h00, exp0: 8'hA5, exp1: 8'h00};
      tbl[1] = '{btn0: 8'h00, ovr0: 8'h00, btn1: 8'h00, ovr1: 8'h08, exp0: 8'h00, exp1: 8'h08};
      tbl[2] = '{btn0: 8'h0F, ovr0: 8'hF0, btn1: 8'h3C, ovr1: 8'h81, exp0: 8'hFF, exp1: 8'hBD};
      tbl[3] = '{btn0: 8'h12, ovr0: 8'h21, btn1: 8'hC0, ovr1: 8'h0C, exp0: 8'h33, exp1: 8'hCC};

      reset        = 1'b1;
      jif.strobe   = 1'b0;
      jif.pad_clk  = '0;
      jif.btn_in   = '0;
      jif.turbo_in = '0;
      jif.override = '0;
      tick();
      step("reset_state", 2'b00, 2'b00, 2'b11, M_ALL);
      reset = 1'b0;

      // Table vectors, both pads shifting together.
      for (int t = 0; t < 4; t++) run_vec(tbl[t], 2'b11, 8, $sformatf("vec%0d", t));

      // Pad 0 only: A5 stream, then over-reads; pad 1 must not move.
      hv = '{btn0: 8'hA5, ovr0: 8'h00, btn1: 8'h5A, ovr1: 8'h00, exp0: 8'hA5, exp1: 8'h5A};
      run_vec(hv, 2'b01, 11, "p0only");

      // Re-strobe after over-read clears reads_done.
      jif.btn_in = 16'h0002;
      jif.strobe = 1'b1;
      step("restrobe", 2'b00, 2'b00, 2'b11, M_DATA | M_DONE);
      jif.strobe = 1'b0;

      // Strobe with a coincident fall: load wins, counter restarts at 0.
      jif.btn_in  = 16'h0001;
      jif.pad_clk = 2'b01;
      tick();
      jif.strobe  = 1'b1;
      jif.pad_clk = 2'b00;
      step("strobe_fall_load", 2'b01, 2'b00, 2'b11, M_DATA | M_DONE);
      jif.strobe  = 1'b0;
      step("strobe_fall_hold", 2'b01, 2'b00, 2'b11, M_DATA | M_DONE);
      for (int k = 1; k <= 8; k++)
         fall(2'b01, $sformatf("sf_shift%0d", k), {1'b0, (k == 8) ? 1'b1 : 1'b0},
              {1'b0, (k == 8) ? 1'b1 : 1'b0}, M_DATA | M_DONE);

      // Autofire with strobe held high so pad_data tracks the phase.
      jif.btn_in   = '0;
      jif.turbo_in = 16'h0001;
      jif.strobe   = 1'b1;
      for (int k = 1; k <= 12; k++)
         step($sformatf("turbo_k%0d", k), {1'b0, exp_ph(k - 1)}, 2'b00,
              {1'b1, exp_ph(k)}, M_ALL);
      jif.turbo_in = '0;
      step("turbo_release", 2'b00, 2'b00, 2'b11, M_ALL);
      jif.turbo_in = 16'h0001;
      for (int k = 1; k <= 5; k++)
         step($sformatf("turbo_repress%0d", k), 2'b00, 2'b00, {1'b1, exp_ph(k)}, M_PH);
      jif.turbo_in = '0;
      jif.strobe   = 1'b0;
      tick();

      // Reset in the middle of a read sequence.
      hv = '{btn0: 8'hA5, ovr0: 8'h00, btn1: 8'h00, ovr1: 8'h00, exp0: 8'hA5, exp1: 8'h00};
      run_vec(hv, 2'b01, 3, "pre_rst");
      reset = 1'b1;
      step("mid_reset", 2'b00, 2'b00, 2'b11, M_ALL);
      reset = 1'b0;
      run_vec(hv, 2'b01, 8, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, got running required finished");
      $fatal(1);
   end

endmodule
